// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file writeback arbiter with pending-write scoreboard
// Define REGFILE_WB_RR_EN for round-robin contention; otherwise the LSU always wins contention.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  logic            w_alu_wins;
  logic            w_alu_grant;
  logic            w_lsu_grant;
  logic            w_any_grant;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;

  logic            r_we;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_pending;

`ifdef REGFILE_WB_RR_EN
  // Records whether the ALU received the most recent grant; reset value lets the ALU win first.
  logic r_last_alu;

  assign w_alu_wins = ~r_last_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_alu <= 1'b0;
    end else if (w_any_grant) begin
      r_last_alu <= w_alu_grant;
    end
  end
`else
  assign w_alu_wins = 1'b0;
`endif

  // rst_n gates the grants so nothing is accepted while reset is held.
  assign w_alu_grant = rst_n & alu_valid & (~lsu_valid | w_alu_wins);
  assign w_lsu_grant = rst_n & lsu_valid & (~alu_valid | ~w_alu_wins);
  assign w_any_grant = w_alu_grant | w_lsu_grant;

  assign alu_ready = w_alu_grant;
  assign lsu_ready = w_lsu_grant;

  assign w_sel_rd   = w_alu_grant ? alu_rd   : lsu_rd;
  assign w_sel_data = w_alu_grant ? alu_data : lsu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= '0;
    end else begin
      r_we <= w_any_grant & (w_sel_rd != 5'd0);
      if (w_any_grant) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  always_comb begin
    w_set = 32'd0;
    w_clr = 32'd0;
    if (issue_valid && (issue_rd != 5'd0)) begin
      w_set[issue_rd] = 1'b1;
    end
    if (r_we) begin
      w_clr[r_waddr] = 1'b1;
    end
  end

  // A set landing on the same edge as a clear wins: a newer producer is now outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~32'd1;
    end
  end

  assign rs1_busy = (rs1_addr != 5'd0) & r_pending[rs1_addr];
  assign rs2_busy = (rs2_addr != 5'd0) & r_pending[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, lsu_valid, issue_valid;
  logic            alu_ready, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            rs1_busy, rs2_busy;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding destinations, who was served last, and the write due next cycle.
  logic [31:0]     m_pend;
  logic            m_last_alu;
  logic            m_we;
  logic [4:0]      m_waddr;
  logic [XLEN-1:0] m_wdata;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_grant();
    if (!rst_n) return 2'b00;
    if (alu_valid && lsu_valid) begin
`ifdef REGFILE_WB_RR_EN
      return m_last_alu ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return {alu_valid, lsu_valid};
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return (a != 5'd0) && m_pend[a];
  endfunction

  task automatic model_reset();
    m_pend = 32'd0; m_last_alu = 1'b0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = '0;
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    rs1_addr = r1; rs2_addr = r2;
    #1;
  endtask

  task automatic tick();
    logic [1:0] g;
    g = exp_grant();
    if (m_we) m_pend[m_waddr] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    if (g != 2'b00) begin
      m_last_alu = g[1];
      m_waddr    = g[1] ? alu_rd : lsu_rd;
      m_wdata    = g[1] ? alu_data : lsu_data;
      m_we       = (m_waddr != 5'd0);
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_in(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1, 5'd9, 5'd9, 5'd0);
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    checks++; if ({alu_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, lsu_ready}); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rs1_busy); end
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0] want [4];
`ifdef REGFILE_WB_RR_EN
    want = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    want = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 5'd1, 32'hA000_0000 + i, 1'b1, 5'd2, 32'hB000_0000 + i, 1'b0, 5'd0, 5'd0, 5'd0);
      checks++;
      if ({alu_ready, lsu_ready} !== want[i]) begin
        errors++; $display("FAIL contention_%0d got=%b exp=%b", i, {alu_ready, lsu_ready}, want[i]);
      end
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== (want[i][1] ? 5'd1 : 5'd2)) begin
        errors++; $display("FAIL contention_wr_%0d got=%b/%0d", i, rf_we, rf_waddr);
      end
    end
  endtask

  task automatic test_single_alu();
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++; if ({alu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {alu_ready, lsu_ready}); end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_scoreboard();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd7);
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_pending got=%b%b exp=11", rs1_busy, rs2_busy); end
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    checks++; if (rf_we !== 1'b1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_wecycle got=%b/%b exp=1/1", rf_we, rs1_busy); end
    tick();
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_busy_cleared got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_same_edge();
    set_in(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd0);
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL same_edge_keep got=%b exp=1", rs1_busy); end
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1) begin errors++; $display("FAIL rd0_busy got=%b%b exp=01", rs1_busy, rs2_busy); end
    tick();
  endtask

  task automatic test_rd_zero();
    set_in(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got=%b exp=1", alu_ready); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_random();
    logic [4:0] r1, r2;
    for (int i = 0; i < 400; i++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      set_in(1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
             1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
             1'($urandom), 5'($urandom), r1, r2);
      checks++;
      if ({alu_ready, lsu_ready} !== exp_grant()) begin
        errors++; $display("FAIL rand_ready_%0d got=%b exp=%b", i, {alu_ready, lsu_ready}, exp_grant());
      end
      checks++;
      if (rs1_busy !== exp_busy(r1) || rs2_busy !== exp_busy(r2)) begin
        errors++; $display("FAIL rand_busy_%0d got=%b%b exp=%b%b", i, rs1_busy, rs2_busy, exp_busy(r1), exp_busy(r2));
      end
      tick();
      checks++;
      if (rf_we !== m_we || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin
        errors++; $display("FAIL rand_write_%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int r = 4; r < 8; r++) begin
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'd0, 5'd0);
      tick();
    end
    set_in(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
    tick();
    set_in(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0, 5'd0, 5'd5, 5'd7);
    checks++; if (rf_we !== 1'b1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL pre_reset got=%b/%b exp=1/1", rf_we, rs1_busy); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got=%b exp=0", rf_we); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b%b exp=00", rs1_busy, rs2_busy); end
    checks++; if ({alu_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL midrst_ready got=%b exp=00", {alu_ready, lsu_ready}); end
    @(posedge clk); #1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd4);
    rst_n = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL postrst_we got=%b exp=0", rf_we); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL postrst_busy got=%b%b exp=00", rs1_busy, rs2_busy); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_alu();
    test_scoreboard();
    test_same_edge();
    test_rd_zero();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
